// File: rtl/i2s_tx.sv
// I2S transmitter: 16-bit offset-binary samples buffered in a small FIFO and sent
// as stereo frames (identical L/R words), two's complement, MSB first.
module i2s_tx #(
  parameter int unsigned DIV_HALF = 5,
  parameter int unsigned SLOTS    = 50,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        i_clk48,
  input  logic        i_rst48_n,
  input  logic [15:0] i_sample,
  input  logic        i_valid,
  input  logic        i_mute,
  output logic        o_bclk,
  output logic        o_lrclk,
  output logic        o_sdata,
  output logic [2:0]  o_level,
  output logic        o_overflow,
  output logic        o_underrun
);

  localparam int unsigned DW   = $clog2(DIV_HALF);
  localparam int unsigned SW   = $clog2(2 * SLOTS);
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW   = $clog2(DEPTH) + 1;
  localparam int unsigned SMAX = 2 * SLOTS - 1;

  logic [DW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [15:0]   word_q, word_d;
  logic [15:0]   last_q, last_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          und_q, und_d;

  logic [15:0]   mem_q [DEPTH];

  logic          tick;
  logic          fall;
  logic          load;
  logic          pop;
  logic          push;
  logic [SW-1:0] slot_nx;
  logic [SW-1:0] pos;
  logic [15:0]   last_src;

  // Next-state logic: divider, slot sequencing, frame load and FIFO bookkeeping.
  always_comb begin
    div_d    = div_q;
    bclk_d   = bclk_q;
    lrclk_d  = lrclk_q;
    sdata_d  = sdata_q;
    slot_d   = slot_q;
    word_d   = word_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = 1'b0;
    und_d    = 1'b0;
    pos      = '0;
    last_src = last_q;

    tick    = (div_q == DW'(DIV_HALF - 1));
    fall    = tick && bclk_q;
    slot_nx = (slot_q == SW'(SMAX)) ? '0 : slot_q + SW'(1);
    load    = fall && (slot_nx == '0);
    pop     = load && (level_q != '0);
    push    = i_valid && ((level_q != LW'(DEPTH)) || pop);

    div_d  = tick ? '0 : div_q + DW'(1);
    bclk_d = tick ? ~bclk_q : bclk_q;

    if (fall) begin
      slot_d  = slot_nx;
      lrclk_d = (slot_nx >= SW'(SLOTS));
      pos     = (slot_nx >= SW'(SLOTS)) ? slot_nx - SW'(SLOTS) : slot_nx;
      // Slot 0 of each channel is the one-BCLK I2S delay; data occupies slots 1..16.
      if ((pos >= SW'(1)) && (pos <= SW'(16))) begin
        sdata_d = word_q[4'(SW'(16) - pos)];
      end else begin
        sdata_d = 1'b0;
      end
    end

    if (load) begin
      if (pop) begin
        last_src = mem_q[rd_ptr_q];
        last_d   = last_src;
        rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end else begin
        und_d = 1'b1;
      end
      word_d = i_mute ? 16'h0000 : {~last_src[15], last_src[14:0]};
    end

    if (push) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    ovf_d = i_valid && !push;

    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
    if (!i_rst48_n) begin
      div_q    <= '0;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b1;
      sdata_q  <= 1'b0;
      slot_q   <= SW'(SMAX);
      word_q   <= 16'h0000;
      last_q   <= 16'h8000;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      sdata_q  <= sdata_d;
      slot_q   <= slot_d;
      word_q   <= word_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      und_q    <= und_d;
    end
  end

  // Sample storage needs no reset; occupancy is tracked by level_q and the pointers.
  always_ff @(posedge i_clk48) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_sample;
    end
  end

  assign o_bclk     = bclk_q;
  assign o_lrclk    = lrclk_q;
  assign o_sdata    = sdata_q;
  assign o_level    = 3'(level_q);
  assign o_overflow = ovf_q;
  assign o_underrun = und_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: constant vector table, directed sequences and random pushes,
// all compared against a frame-level reference model.
module tb_i2s_tx;

  localparam int DIV_HALF = 5;
  localparam int SLOTS    = 50;
  localparam int DEPTH    = 4;
  localparam int FRAME    = 2 * SLOTS * 2 * DIV_HALF;

  logic        clk;
  logic        rst_n;
  logic [15:0] sample;
  logic        valid;
  logic        mute;
  logic        bclk, lrclk, sdata, ovf, und;
  logic [2:0]  level;

  i2s_tx #(.DIV_HALF(DIV_HALF), .SLOTS(SLOTS), .DEPTH(DEPTH)) dut (
    .i_clk48    (clk),
    .i_rst48_n  (rst_n),
    .i_sample   (sample),
    .i_valid    (valid),
    .i_mute     (mute),
    .o_bclk     (bclk),
    .o_lrclk    (lrclk),
    .o_sdata    (sdata),
    .o_level    (level),
    .o_overflow (ovf),
    .o_underrun (und)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: edges since reset release, FIFO contents, held words.
  int          n;
  logic [15:0] q[$];
  logic [15:0] m_last;
  logic [15:0] m_word;
  logic        m_bclk, m_lr, m_sd, m_ov, m_ur;
  logic [7:0]  d_out;

  function automatic logic [7:0] pk(input logic b, input logic l, input logic s,
                                    input logic o, input logic u, input logic [2:0] lv);
    return {b, l, s, o, u, lv};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    q.delete();
    m_last = 16'h8000;
    m_word = 16'h0000;
    m_bclk = 1'b0;
    m_lr   = 1'b1;
    m_sd   = 1'b0;
    m_ov   = 1'b0;
    m_ur   = 1'b0;
  endtask

  // One clock edge of the spec's frame arithmetic: bclk phase from n, slot from fall count.
  task automatic model_edge(input logic v, input logic [15:0] smp, input logic mu);
    int k, s, p;
    n++;
    m_ov   = 1'b0;
    m_ur   = 1'b0;
    m_bclk = ((n / DIV_HALF) % 2) == 1;
    if ((n % (2 * DIV_HALF)) == 0) begin
      k    = n / (2 * DIV_HALF);
      s    = (k - 1) % (2 * SLOTS);
      m_lr = (s >= SLOTS);
      p    = s % SLOTS;
      if (s == 0) begin
        if (q.size() > 0) m_last = q.pop_front();
        else m_ur = 1'b1;
        m_word = mu ? 16'h0000 : (m_last ^ 16'h8000);
      end
      m_sd = (p >= 1 && p <= 16) ? m_word[16 - p] : 1'b0;
    end
    if (v) begin
      if (q.size() < DEPTH) q.push_back(smp);
      else m_ov = 1'b1;
    end
  endtask

  task automatic step(input logic v, input logic [15:0] smp, input logic mu);
    valid  = v;
    sample = smp;
    mute   = mu;
    @(posedge clk);
    #1;
    model_edge(v, smp, mu);
    d_out = pk(bclk, lrclk, sdata, ovf, und, level);
    check($sformatf("model edge %0d", n), int'(d_out),
          int'(pk(m_bclk, m_lr, m_sd, m_ov, m_ur, 3'(q.size()))));
  endtask

  task automatic run_to(input int target);
    while (n < target) step(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    valid  = 1'b0;
    sample = 16'h0000;
    mute   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset state", int'(pk(bclk, lrclk, sdata, ovf, und, level)), int'(8'h40));
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int          edge_n;
    logic        valid;
    logic [15:0] sample;
    logic        mute;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];
  int   pulses;
  int   ones;

  initial begin
    rst_n  = 1'b0;
    valid  = 1'b0;
    sample = 16'h0000;
    mute   = 1'b0;
    model_reset();

    // Single C000 push before the first load: word 0x4000, repeated after underrun.
    vecs.push_back('{2,    1'b1, 16'hC000, 1'b0, pk(0, 1, 0, 0, 0, 3'd1)});
    vecs.push_back('{4,    1'b0, 16'h0000, 1'b0, pk(0, 1, 0, 0, 0, 3'd1)});
    vecs.push_back('{5,    1'b0, 16'h0000, 1'b0, pk(1, 1, 0, 0, 0, 3'd1)});
    vecs.push_back('{10,   1'b0, 16'h0000, 1'b0, pk(0, 0, 0, 0, 0, 3'd0)});
    vecs.push_back('{20,   1'b0, 16'h0000, 1'b0, pk(0, 0, 0, 0, 0, 3'd0)});
    vecs.push_back('{30,   1'b0, 16'h0000, 1'b0, pk(0, 0, 1, 0, 0, 3'd0)});
    vecs.push_back('{40,   1'b0, 16'h0000, 1'b0, pk(0, 0, 0, 0, 0, 3'd0)});
    vecs.push_back('{180,  1'b0, 16'h0000, 1'b0, pk(0, 0, 0, 0, 0, 3'd0)});
    vecs.push_back('{510,  1'b0, 16'h0000, 1'b0, pk(0, 1, 0, 0, 0, 3'd0)});
    vecs.push_back('{520,  1'b0, 16'h0000, 1'b0, pk(0, 1, 0, 0, 0, 3'd0)});
    vecs.push_back('{530,  1'b0, 16'h0000, 1'b0, pk(0, 1, 1, 0, 0, 3'd0)});
    vecs.push_back('{1010, 1'b0, 16'h0000, 1'b0, pk(0, 0, 0, 0, 1, 3'd0)});
    vecs.push_back('{1011, 1'b0, 16'h0000, 1'b0, pk(0, 0, 0, 0, 0, 3'd0)});
    vecs.push_back('{1030, 1'b0, 16'h0000, 1'b0, pk(0, 0, 1, 0, 0, 3'd0)});

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      run_to(vecs[i].edge_n - 1);
      step(vecs[i].valid, vecs[i].sample, vecs[i].mute);
      check($sformatf("vec edge %0d", vecs[i].edge_n), int'(d_out), int'(vecs[i].exp));
    end

    // No pushes at all: first frame underruns on midscale.
    do_reset();
    run_to(10);
    check("idle first underrun", int'(d_out[3]), 1);
    run_to(FRAME + 20);

    // One push per frame period: in-order delivery, no pulses after the first frame.
    do_reset();
    pulses = 0;
    while (n < 7 * FRAME + 20) begin
      step(((n + 1) % FRAME) == 500, 16'((n + 1) / FRAME + 1), 1'b0);
      if (n > FRAME + 10 && (d_out[4] || d_out[3])) pulses++;
    end
    check("paced no pulses", pulses, 0);

    // Five back-to-back pushes: fifth overflows, then four frames and an underrun.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'h1000 * 16'(i + 1), 1'b0);
      if (i == 3) check("b2b level full", int'(d_out[2:0]), 4);
      if (i == 4) check("b2b overflow", int'(d_out[4]), 1);
    end
    run_to(4 * FRAME + 10);
    check("b2b underrun after four", int'(d_out[3]), 1);
    run_to(5 * FRAME + 20);

    // Full FIFO with push on the load edge and mute sampled there.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 16'hA000 + 16'(i), 1'b0);
    run_to(9);
    step(1'b1, 16'h7FFF, 1'b1);
    check("load push no overflow", int'(d_out[4]), 0);
    check("load push level", int'(d_out[2:0]), 4);
    ones = 0;
    while (n < FRAME + 9) begin
      step(1'b0, 16'h0000, 1'b0);
      if (d_out[5]) ones++;
    end
    check("muted frame data", ones, 0);
    run_to(2 * FRAME + 20);

    // Random bursty pushes and mute against the model.
    do_reset();
    for (int i = 0; i < 20000; i++) begin
      step($urandom_range(0, 299) == 0, 16'($urandom), $urandom_range(0, 7) == 0);
    end

    // Asynchronous reset mid-frame with three samples queued.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 16'h1234 + 16'(i), 1'b0);
    run_to(300);
    check("pre-reset level", int'(d_out[2:0]), 3);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset outputs", int'(pk(bclk, lrclk, sdata, ovf, und, level)), int'(8'h40));
    @(posedge clk);
    #1;
    check("held reset outputs", int'(pk(bclk, lrclk, sdata, ovf, und, level)), int'(8'h40));
    #2;
    rst_n = 1'b1;
    model_reset();
    run_to(10);
    check("post-reset underrun", int'(d_out[3]), 1);
    run_to(FRAME + 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Audio output serializer and sink for the 48 kHz sample stream from the waveform generators.
- Accepts 16-bit samples on a one-cycle strobe into a 4-entry FIFO, then transmits each sample as a stereo I2S frame with identical left and right data.
- Default framing gives exactly 1000 i_clk48 cycles per frame, which is 48 kHz at 48 MHz.
- The FIFO absorbs phase offset between the generator strobe and the frame boundary.

Parameters:
- DIV_HALF, 5: i_clk48 cycles per o_bclk half-period. Must be ≥2.
- SLOTS, 50: o_bclk periods per channel. Must be ≥17. Frame length is 2*SLOTS*2*DIV_HALF cycles.
- DEPTH, 4: FIFO entries. Must be a power of 2.

Ports:
- i_clk48  in  1  48 MHz system clock.
- i_rst48_n  in  1  reset, asynchronous, active-low.
- i_sample  in  16  sample, offset-binary as produced by the generators.
- i_valid  in  1  one-cycle strobe; push i_sample.
- i_mute  in  1  transmit zero data while still consuming samples.
- o_bclk  out  1  I2S bit clock.
- o_lrclk  out  1  I2S word select; 0 = left.
- o_sdata  out  1  I2S serial data, MSB first, two's complement.
- o_level  out  3  FIFO occupancy, 0..DEPTH.
- o_overflow  out  1  one-cycle pulse: push dropped.
- o_underrun  out  1  one-cycle pulse: frame started with FIFO empty.

Behaviour:
- Reset (async assert, sync-deasserted usage assumed by system):
  - Outputs: o_bclk=0, o_lrclk=1, o_sdata=0, o_level=0, o_overflow=0, o_underrun=0.
  - Internal state: divider=0, slot counter=2*SLOTS-1, FIFO empty, last-sample register=16'h8000 (midscale).
- Divider:
  - Counts 0..DIV_HALF-1; at terminal count o_bclk toggles.
  - First toggle after reset is a rising edge, DIV_HALF cycles after deassert.
- Falling edge of o_bclk (all output updates happen here, registered):
  - Slot counter s advances modulo 2*SLOTS.
  - o_lrclk = (s ≥ SLOTS).
  - Channel position p = s mod SLOTS.
  - o_sdata = word[16-p] for p in 1..16, else 0. This gives the standard I2S one-BCLK delay after o_lrclk change.
- Frame load at the falling edge where s becomes 0:
  - FIFO non-empty: pop head into the last-sample register.
  - FIFO empty: keep the last-sample register and pulse o_underrun.
  - Transmit word = {~last[15], last[14:0]} (offset-binary to two's complement), or 16'h0000 if i_mute is sampled high at that edge.
  - The word is held for the whole frame; both channels carry the same word.
- FIFO push:
  - i_valid with level<DEPTH: write, level+1.
  - i_valid with level==DEPTH and no pop that cycle: drop i_sample and pulse o_overflow. The FIFO is unchanged.
  - Push and pop in the same cycle: both happen, level unchanged. When full this is not an overflow. When empty the pop sees empty (underrun) and the push is written.
- Pointers wrap modulo DEPTH. o_level reflects the update one cycle after the push/pop edge.
- i_valid asserted on consecutive cycles: each cycle is a separate push.
- Reset mid-frame: immediate return to reset values. The FIFO is flushed and the partial frame is abandoned.

Test Plan:
- Reset deassert, no i_valid:
  - First o_bclk rise at cycle 5, first fall at cycle 10.
  - o_lrclk goes 0 at cycle 10 and o_underrun pulses there.
  - Transmitted word is 16'h0000 (midscale 8000 converted).
  - o_lrclk period is 1000 cycles.
- Push 16'hC000 once, before the first frame load:
  - o_level goes to 1.
  - Left channel slots 1..16 carry 0100_0000_0000_0000 MSB first, with the MSB on the BCLK after o_lrclk falls.
  - Slots 17..49 are 0.
  - Right channel is identical.
  - o_level returns to 0 at the load.
- i_valid every 1000 cycles with samples 16'h0001, 16'h0002, …:
  - Frames transmit the samples in order with no drops.
  - o_overflow and o_underrun stay 0 after the first frame.
- Push 5 samples back-to-back:
  - o_level reaches 4.
  - 5th push pulses o_overflow; the 5th sample is never transmitted.
  - The first 4 samples are sent in the next 4 frames, then o_underrun pulses with the 4th sample repeated.
- FIFO full with i_valid coinciding with the frame-load pop: no o_overflow, o_level stays 4. i_mute=1 at a load: that frame's o_sdata is all 0 and the pop still occurs.
- Assert i_rst48_n low mid-frame while o_level=3: outputs return immediately (asynchronously) to reset values, o_level=0, and the next frame underruns.
